// File: rtl/biquad_cascade.sv
// biquad_cascade: multi-channel cascade of Direct Form I biquad sections that
// share a single time-multiplexed multiplier (5 MAC cycles + 1 commit cycle per
// section, channel-major / band-minor order).
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       frame handshake (accepted only in IDLE)
//   i_data                  one signed sample per channel, ch0 in LSBs
//   o_valid, o_data, o_sat  one-cycle result pulse, filtered frame, clamp flag
//   i_coef_we, i_coef_band, i_coef_idx, i_coef_data
//                           shadow coefficient write (idx 0..4 = b0,b1,b2,a1,a2)
//   i_commit                copy shadow bank to active bank (deferred while busy)
//   i_bypass                per-section bypass (y = x, history held at zero)
//   i_clear                 zero all filter history (IDLE only)
module biquad_cascade #(
    parameter int DATA_W  = 32,
    parameter int FRAC    = 15,
    parameter int N_BANDS = 4,
    parameter int N_CH    = 2
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst_n,
    input  logic                                              i_valid,
    output logic                                              o_ready,
    input  logic [N_CH*DATA_W-1:0]                            i_data,
    output logic                                              o_valid,
    output logic [N_CH*DATA_W-1:0]                            o_data,
    output logic                                              o_sat,
    input  logic                                              i_coef_we,
    input  logic [((N_BANDS > 1) ? $clog2(N_BANDS) : 1)-1:0] i_coef_band,
    input  logic [2:0]                                        i_coef_idx,
    input  logic [DATA_W-1:0]                                 i_coef_data,
    input  logic                                              i_commit,
    input  logic [N_BANDS-1:0]                                i_bypass,
    input  logic                                              i_clear
);

    localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int N_SEC  = N_BANDS * N_CH;
    localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int ACC_W  = 2 * DATA_W + 4;

    typedef logic signed [DATA_W-1:0] smp_t;
    localparam smp_t COEF_ONE = smp_t'(DATA_W'(1) << FRAC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    smp_t                     r_shd [N_BANDS][5];
    smp_t                     r_act [N_BANDS][5];
    smp_t                     r_x1 [N_SEC];
    smp_t                     r_x2 [N_SEC];
    smp_t                     r_y1 [N_SEC];
    smp_t                     r_y2 [N_SEC];
    smp_t                     r_in [N_CH];
    smp_t                     r_res [N_CH];
    smp_t                     r_x;
    logic signed [ACC_W-1:0]  r_acc;
    logic [2:0]               r_step;
    logic [BAND_W-1:0]        r_band;
    logic [CH_W-1:0]          r_ch;
    logic [SEC_W-1:0]         r_sec;
    logic                     r_pend, r_sat_acc;
    logic                     r_o_valid, r_o_sat;
    logic [N_CH*DATA_W-1:0]   r_o_data;

    logic                     w_accept, w_last_band, w_last_ch, w_ovf, w_clamp, w_byp;
    smp_t                     w_coef, w_dat, w_y_sat, w_y;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, w_shift;

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;
    assign o_sat   = r_o_sat;

    assign w_last_band = (r_band == BAND_W'(N_BANDS - 1));
    assign w_last_ch   = (r_ch == CH_W'(N_CH - 1));
    // i_clear wins over i_valid: the frame is dropped, not deferred
    assign w_accept    = (r_state == S_IDLE) && i_valid && !i_clear;
    assign w_byp       = i_bypass[r_band];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_step == 3'd5 && w_last_band && w_last_ch) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared multiplier operand select: step 0..4 -> b0*x, b1*x1, b2*x2, a1*y1, a2*y2
    always_comb begin
        w_coef = r_act[r_band][0];
        w_dat  = r_x;
        case (r_step)
            3'd1:    begin w_coef = r_act[r_band][1]; w_dat = r_x1[r_sec]; end
            3'd2:    begin w_coef = r_act[r_band][2]; w_dat = r_x2[r_sec]; end
            3'd3:    begin w_coef = r_act[r_band][3]; w_dat = r_y1[r_sec]; end
            3'd4:    begin w_coef = r_act[r_band][4]; w_dat = r_y2[r_sec]; end
            default: begin w_coef = r_act[r_band][0]; w_dat = r_x; end
        endcase
    end

    assign w_prod     = w_coef * w_dat;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_shift    = r_acc >>> FRAC;
    // Out of range when the bits above the output sign bit are not all copies of it
    assign w_ovf      = (|w_shift[ACC_W-1:DATA_W-1]) && !(&w_shift[ACC_W-1:DATA_W-1]);
    assign w_y_sat    = !w_ovf ? w_shift[DATA_W-1:0]
                      : (w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
    assign w_y        = w_byp ? r_x : w_y_sat;
    assign w_clamp    = !w_byp && w_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shd     <= '{default: '{COEF_ONE, smp_t'(0), smp_t'(0), smp_t'(0), smp_t'(0)}};
            r_act     <= '{default: '{COEF_ONE, smp_t'(0), smp_t'(0), smp_t'(0), smp_t'(0)}};
            r_x1      <= '{default: smp_t'(0)};
            r_x2      <= '{default: smp_t'(0)};
            r_y1      <= '{default: smp_t'(0)};
            r_y2      <= '{default: smp_t'(0)};
            r_in      <= '{default: smp_t'(0)};
            r_res     <= '{default: smp_t'(0)};
            r_x       <= '0;
            r_acc     <= '0;
            r_step    <= '0;
            r_band    <= '0;
            r_ch      <= '0;
            r_sec     <= '0;
            r_pend    <= 1'b0;
            r_sat_acc <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_sat   <= 1'b0;
            r_o_data  <= '0;
        end else begin
            r_o_valid <= 1'b0;

            if (i_coef_we && i_coef_idx < 3'd5 && 32'(i_coef_band) < N_BANDS)
                r_shd[i_coef_band][i_coef_idx] <= i_coef_data;

            // Commit is applied in IDLE before any same-cycle capture takes effect,
            // so an accepted frame always sees the freshly committed bank.
            if (r_state == S_IDLE) begin
                if (i_commit || r_pend) begin
                    r_act  <= r_shd;
                    r_pend <= 1'b0;
                end
            end else if (i_commit) begin
                r_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_clear) begin
                        r_x1 <= '{default: smp_t'(0)};
                        r_x2 <= '{default: smp_t'(0)};
                        r_y1 <= '{default: smp_t'(0)};
                        r_y2 <= '{default: smp_t'(0)};
                    end else if (i_valid) begin
                        for (int unsigned c = 0; c < N_CH; c++)
                            r_in[c] <= i_data[c*DATA_W +: DATA_W];
                        r_x       <= i_data[DATA_W-1:0];
                        r_step    <= '0;
                        r_band    <= '0;
                        r_ch      <= '0;
                        r_sec     <= '0;
                        r_sat_acc <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_step != 3'd5) begin
                        if (r_step == 3'd0)      r_acc <= w_prod_ext;
                        else if (r_step < 3'd3)  r_acc <= r_acc + w_prod_ext;
                        else                     r_acc <= r_acc - w_prod_ext;
                        r_step <= r_step + 3'd1;
                    end else begin
                        if (w_byp) begin
                            r_x1[r_sec] <= '0;
                            r_x2[r_sec] <= '0;
                            r_y1[r_sec] <= '0;
                            r_y2[r_sec] <= '0;
                        end else begin
                            r_x2[r_sec] <= r_x1[r_sec];
                            r_x1[r_sec] <= r_x;
                            r_y2[r_sec] <= r_y1[r_sec];
                            r_y1[r_sec] <= w_y;
                        end
                        r_sat_acc <= r_sat_acc | w_clamp;
                        r_step    <= '0;
                        r_sec     <= r_sec + SEC_W'(1);
                        if (w_last_band) begin
                            r_res[r_ch] <= w_y;
                            r_band      <= '0;
                            if (!w_last_ch) begin
                                r_ch <= r_ch + CH_W'(1);
                                r_x  <= r_in[r_ch + CH_W'(1)];
                            end
                        end else begin
                            r_band <= r_band + BAND_W'(1);
                            r_x    <= w_y;
                        end
                    end
                end
                S_DONE: begin
                    for (int unsigned c = 0; c < N_CH; c++)
                        r_o_data[c*DATA_W +: DATA_W] <= r_res[c];
                    r_o_sat   <= r_sat_acc;
                    r_o_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade.sv
// tb_biquad_cascade: self-checking bench for biquad_cascade (2 bands, 2 channels,
// Q15, 32-bit). Directed scenarios plus randomized frames compared against a
// frame-level arithmetic reference model.
module tb_biquad_cascade;

    localparam int DW = 32;
    localparam int FR = 15;
    localparam int NB = 2;
    localparam int NC = 2;
    localparam logic signed [67:0] YMAX = 68'sd2147483647;
    localparam logic signed [67:0] YMIN = -68'sd2147483648;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_valid, o_ready, o_valid, o_sat;
    logic [NC*DW-1:0] i_data, o_data;
    logic           i_coef_we, i_commit, i_clear;
    logic           i_coef_band;
    logic [2:0]     i_coef_idx;
    logic [DW-1:0]  i_coef_data;
    logic [NB-1:0]  i_bypass;

    always #5 clk = ~clk;

    biquad_cascade #(.DATA_W(DW), .FRAC(FR), .N_BANDS(NB), .N_CH(NC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .o_data(o_data), .o_sat(o_sat),
        .i_coef_we(i_coef_we), .i_coef_band(i_coef_band), .i_coef_idx(i_coef_idx),
        .i_coef_data(i_coef_data), .i_commit(i_commit), .i_bypass(i_bypass),
        .i_clear(i_clear)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    // Reference model state: coefficient banks and per channel/band history
    logic signed [31:0] m_shd [NB][5];
    logic signed [31:0] m_act [NB][5];
    logic signed [31:0] m_x1 [NC][NB];
    logic signed [31:0] m_x2 [NC][NB];
    logic signed [31:0] m_y1 [NC][NB];
    logic signed [31:0] m_y2 [NC][NB];
    logic [NB-1:0]      m_byp;
    logic signed [31:0] exp_y [NC];
    logic               exp_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic m_clear;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) begin
                m_x1[c][b] = 0; m_x2[c][b] = 0; m_y1[c][b] = 0; m_y2[c][b] = 0;
            end
    endtask

    task automatic m_reset;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 5; k++) begin
                m_shd[b][k] = (k == 0) ? 32'sd32768 : 32'sd0;
                m_act[b][k] = m_shd[b][k];
            end
        m_clear();
    endtask

    // One frame through the cascade using the textbook DF-I difference equation
    task automatic model_frame(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [67:0] x, y, acc;
        exp_sat = 1'b0;
        for (int c = 0; c < NC; c++) begin
            x = (c == 0) ? 68'(a) : 68'(b);
            for (int k = 0; k < NB; k++) begin
                if (m_byp[k]) begin
                    y = x;
                    m_x1[c][k] = 0; m_x2[c][k] = 0; m_y1[c][k] = 0; m_y2[c][k] = 0;
                end else begin
                    acc = 68'(m_act[k][0]) * x
                        + 68'(m_act[k][1]) * 68'(m_x1[c][k])
                        + 68'(m_act[k][2]) * 68'(m_x2[c][k])
                        - 68'(m_act[k][3]) * 68'(m_y1[c][k])
                        - 68'(m_act[k][4]) * 68'(m_y2[c][k]);
                    y = acc >>> FR;
                    if (y > YMAX) begin y = YMAX; exp_sat = 1'b1; end
                    if (y < YMIN) begin y = YMIN; exp_sat = 1'b1; end
                    m_x2[c][k] = m_x1[c][k];
                    m_x1[c][k] = x[31:0];
                    m_y2[c][k] = m_y1[c][k];
                    m_y1[c][k] = y[31:0];
                end
                x = y;
            end
            exp_y[c] = x[31:0];
        end
    endtask

    task automatic write_coef(input int b, input int k, input logic signed [31:0] v);
        i_coef_we = 1'b1; i_coef_band = b[0]; i_coef_idx = k[2:0]; i_coef_data = v;
        tick();
        i_coef_we = 1'b0;
        m_shd[b][k] = v;
    endtask

    task automatic commit_idle;
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        m_act = m_shd;
    endtask

    task automatic start_frame(input logic signed [31:0] a, input logic signed [31:0] b);
        int g = 0;
        while (!o_ready && g < 200) begin tick(); g++; end
        check("ready", 32'(o_ready), 32'd1);
        m_byp = i_bypass;
        i_data = {b, a};
        i_valid = 1'b1;
        model_frame(a, b);
        tick();
        i_valid = 1'b0;
        lat = 0;
    endtask

    task automatic finish_frame(input string tag);
        logic [NC*DW-1:0] held;
        while (!o_valid && lat < 200) tick();
        check({tag, "_lat"}, 32'(lat), 32'd25);
        check({tag, "_ch0"}, o_data[31:0], exp_y[0]);
        check({tag, "_ch1"}, o_data[63:32], exp_y[1]);
        check({tag, "_sat"}, 32'(o_sat), 32'(exp_sat));
        held = o_data;
        tick();
        check({tag, "_pulse"}, 32'(o_valid), 32'd0);
        check({tag, "_hold"}, o_data[31:0], held[31:0]);
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_valid) p++;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_reset();
    endtask

    initial begin
        int p;
        logic signed [31:0] xa, xb;
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_coef_we = 1'b0; i_coef_band = 1'b0;
        i_coef_idx = '0; i_coef_data = '0; i_commit = 1'b0; i_bypass = '0; i_clear = 1'b0;
        lat = 0;
        m_reset();
        m_byp = '0;
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data0", o_data[31:0], 32'd0);
        check("rst_data1", o_data[63:32], 32'd0);
        check("rst_sat", 32'(o_sat), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(o_ready), 32'd1);

        // Identity
        start_frame(32'sd1000, -32'sd1000);
        finish_frame("ident");
        check("ident_c0", o_data[31:0], 32'd1000);
        check("ident_c1", o_data[63:32], 32'hFFFFFC18);

        // Clear with valid: frame dropped, history zeroed
        i_clear = 1'b1; i_valid = 1'b1; i_data = {32'd7, 32'd7};
        tick();
        i_clear = 1'b0; i_valid = 1'b0;
        m_clear();
        count_pulses(40, p);
        check("clr_noframe", 32'(p), 32'd0);

        // FIR impulse
        write_coef(0, 0, 32'sd16384);
        write_coef(0, 1, 32'sd8192);
        commit_idle();
        start_frame(32'sd32768, 32'sd0); finish_frame("fir0"); check("fir0_c", o_data[31:0], 32'd16384);
        start_frame(32'sd0, 32'sd0);     finish_frame("fir1"); check("fir1_c", o_data[31:0], 32'd8192);
        start_frame(32'sd0, 32'sd0);     finish_frame("fir2"); check("fir2_c", o_data[31:0], 32'd0);

        // Mid-frame reset, then feedback from clean history
        start_frame(32'sd500, 32'sd600);
        repeat (9) tick();
        rst_n = 1'b0;
        #2;
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_data", o_data[31:0], 32'd0);
        tick();
        rst_n = 1'b1;
        m_reset();
        count_pulses(40, p);
        check("mrst_noframe", 32'(p), 32'd0);
        write_coef(0, 3, -32'sd16384);
        commit_idle();
        start_frame(32'sd32768, 32'sd0); finish_frame("fb0"); check("fb0_c", o_data[31:0], 32'd32768);
        start_frame(32'sd32768, 32'sd0); finish_frame("fb1"); check("fb1_c", o_data[31:0], 32'd49152);
        start_frame(32'sd32768, 32'sd0); finish_frame("fb2"); check("fb2_c", o_data[31:0], 32'd57344);

        // Saturation both directions
        do_reset();
        write_coef(0, 0, 32'sd131072);
        commit_idle();
        start_frame(32'sh7FFF0000, 32'sh80010000);
        finish_frame("sat");
        check("sat_hi", o_data[31:0], 32'h7FFFFFFF);
        check("sat_lo", o_data[63:32], 32'h80000000);
        check("sat_flag", 32'(o_sat), 32'd1);
        start_frame(32'sd0, 32'sd0);
        finish_frame("unsat");
        check("unsat_flag", 32'(o_sat), 32'd0);

        // Commit while busy is deferred; i_valid while busy is dropped
        do_reset();
        start_frame(32'sd100, 32'sd100);
        repeat (4) tick();
        i_coef_we = 1'b1; i_coef_band = 1'b0; i_coef_idx = 3'd0; i_coef_data = 32'd16384;
        i_commit = 1'b1;
        tick();
        i_coef_we = 1'b0; i_commit = 1'b0;
        m_shd[0][0] = 32'sd16384;
        i_valid = 1'b1;
        repeat (3) tick();
        i_valid = 1'b0;
        finish_frame("busy0");
        check("busy0_c", o_data[31:0], 32'd100);
        m_act = m_shd;
        count_pulses(40, p);
        check("busy_nobuf", 32'(p), 32'd0);
        start_frame(32'sd100, 32'sd100);
        finish_frame("busy1");
        check("busy1_c", o_data[31:0], 32'd50);

        // Randomized frames against the model
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < NB; b++)
                    for (int k = 0; k < 5; k++) begin
                        if ($urandom_range(0, 5) == 0)
                            write_coef(b, k, 32'(int'($urandom_range(0, 262143)) - 131072));
                        else
                            write_coef(b, k, 32'(int'($urandom_range(0, 65535)) - 32768));
                    end
                commit_idle();
            end
            i_bypass = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                i_clear = 1'b1;
                tick();
                i_clear = 1'b0;
                m_clear();
            end
            if ($urandom_range(0, 2) == 0) begin
                xa = $urandom();
                xb = $urandom();
            end else begin
                xa = 32'(int'($urandom_range(0, 131071)) - 65536);
                xb = 32'(int'($urandom_range(0, 131071)) - 65536);
            end
            start_frame(xa, xb);
            finish_frame("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/biquad_cascade.md
BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample and coefficient width (signed).
REQ-002 SHALL have parameter FRAC, default 15, meaning fractional bits of coefficients (Q-format).
REQ-003 SHALL have parameter N_BANDS, default 4, meaning number of cascaded biquad sections.
REQ-004 SHALL have parameter N_CH, default 2, meaning number of independent audio channels.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_clk, input, 1 bit, meaning system clock (rising edge).
REQ-007 SHALL have port i_rst_n, input, 1 bit, meaning async active-low reset.
REQ-008 SHALL have port i_valid, input, 1 bit, meaning input sample frame present.
REQ-009 SHALL have port o_ready, output, 1 bit, meaning block can accept a frame.
REQ-010 SHALL have port i_data, input, N_CH*DATA_W bits, meaning one sample per channel, ch0 in LSBs.
REQ-011 SHALL have port o_valid, output, 1 bit, meaning one-cycle pulse, o_data updated.
REQ-012 SHALL have port o_data, output, N_CH*DATA_W bits, meaning filtered frame, same packing.
REQ-013 SHALL have port o_sat, output, 1 bit, meaning any clamp occurred in the frame on o_data.
REQ-014 SHALL have port i_coef_we, input, 1 bit, meaning write i_coef_data into the shadow bank.
REQ-015 SHALL have port i_coef_band, input, clog2(N_BANDS) bits, meaning target section.
REQ-016 SHALL have port i_coef_idx, input, 3 bits, meaning 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
REQ-017 SHALL have port i_coef_data, input, DATA_W bits, meaning signed Q(FRAC) coefficient; a0 fixed at 1.0.
REQ-018 SHALL have port i_commit, input, 1 bit, meaning copy the shadow bank to the active bank.
REQ-019 SHALL have port i_bypass, input, N_BANDS bits, meaning per-section bypass.
REQ-020 SHALL have port i_clear, input, 1 bit, meaning zero all filter history.

Function
REQ-021 SHALL compute each section as Direct Form I: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; y = acc >>> FRAC (arithmetic).
- Accumulator width 2*DATA_W+4.
REQ-022 SHALL saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then set the frame saturation flag.
REQ-023 SHALL keep separate x1/x2/y1/y2 history per channel per section, updated after each section's commit.
REQ-024 SHALL use one shared multiplier, time-multiplexed, with a fixed cost per section:
- 5 MAC cycles plus 1 commit cycle.
REQ-025 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: o_ready=1; i_valid=1 captures i_data and goes to RUN.
- RUN: iterates channel-major, band-minor, with section output feeding the next band.
- DONE: drives o_data/o_sat and pulses o_valid.
REQ-026 SHALL have latency L = 6*N_BANDS*N_CH + 1 cycles from accept edge to the o_valid cycle.
REQ-027 SHALL hold o_ready=0 outside IDLE; i_valid there is ignored and not buffered.
REQ-028 SHALL hold o_data and o_sat stable between o_valid pulses.
REQ-029 SHALL treat a bypassed section as y=x with its history held at zero; cycle cost and latency are unchanged.
REQ-030 SHALL accept i_coef_we in any state.
REQ-031 SHALL apply i_commit immediately in IDLE; if asserted while busy, latch it and apply it on entering IDLE.
REQ-032 SHALL apply commit before capture when commit and i_valid coincide in IDLE, so the frame uses the new coefficients.
REQ-033 SHALL honour i_clear only in IDLE, taking priority over i_valid in the same cycle (frame not accepted); while busy it is ignored.

Reset
REQ-034 SHALL, during reset, force: state IDLE, o_ready=1 after release, o_valid=0, o_data=0, o_sat=0.
- All history zero; pending commit cleared.
REQ-035 SHALL reset both coefficient banks to identity: b0 = 1<<FRAC, all others 0.
REQ-036 SHALL, on reset asserted mid-frame, abort the frame with no o_valid and start clean.

Verification (N_BANDS=2, N_CH=2, FRAC=15, DATA_W=32, L=25)
REQ-037 SHALL cover identity: reset, frame {1000, -1000} -> o_valid exactly 25 cycles later, o_data {1000, -1000}, o_sat=0.
REQ-038 SHALL cover FIR impulse: band0 b0=16384, b1=8192, commit; impulse 32768 then 0, 0 on ch0 -> ch0 outputs 16384, 8192, 0.
REQ-039 SHALL cover feedback: band0 a1=-16384, commit; step 32768 -> ch0 outputs 32768, 49152, 57344.
REQ-040 SHALL cover saturation: b0=131072; x=0x7FFF0000 -> output 0x7FFFFFFF, o_sat=1; next frame x=0 -> o_sat=0.
REQ-041 SHALL cover busy commit: write b0=16384 and pulse i_commit at cycle 5 of a frame (x=100) -> that frame outputs 100; next frame x=100 outputs 50.
REQ-042 SHALL cover mid-frame reset and clear: i_rst_n low at cycle 10 -> no o_valid, history zero; separately, i_clear with i_valid in IDLE -> frame not accepted, next impulse response matches REQ-038.
